// File: rtl/fpu_selfcheck_seq_pkg.sv
// fpu_selfcheck_pkg: shared types and constants for the add/sub self-check
// sequencer.
//   state_e  : sequencer FSM states
//   FLG_*    : bit positions inside the 5-bit flag word
//              {invalid, overflow, underflow, inexact, zero}
//   fp_width : total FP word width from exponent and stored mantissa widths
package fpu_selfcheck_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned FLG_W         = 5;
  localparam int unsigned FLG_INVALID   = 4;
  localparam int unsigned FLG_OVERFLOW  = 3;
  localparam int unsigned FLG_UNDERFLOW = 2;
  localparam int unsigned FLG_INEXACT   = 1;
  localparam int unsigned FLG_ZERO      = 0;

  function automatic int unsigned fp_width(input int unsigned exp_w,
                                           input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/fpu_selfcheck_seq_if.sv
// fpu_selfcheck_seq_if: vector-memory bus between the self-check sequencer
// (master) and the synchronous vector memory (slave).
//   vec_rd_en / vec_addr         : read strobe and address from the sequencer
//   vec_x / vec_y / vec_exp      : operands and expected result, valid the
//                                  cycle after the address
//   vec_flags                    : expected {invalid,overflow,underflow,inexact,zero}
interface fpu_selfcheck_seq_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned ADDR_W = 14
);
  import fpu_selfcheck_pkg::*;

  localparam int unsigned FP_W = fp_width(EXP_W, MAN_W);

  logic              vec_rd_en;
  logic [ADDR_W-1:0] vec_addr;
  logic [FP_W-1:0]   vec_x;
  logic [FP_W-1:0]   vec_y;
  logic [FP_W-1:0]   vec_exp;
  logic [FLG_W-1:0]  vec_flags;

  modport master (
    output vec_rd_en, vec_addr,
    input  vec_x, vec_y, vec_exp, vec_flags
  );

  modport slave (
    input  vec_rd_en, vec_addr,
    output vec_x, vec_y, vec_exp, vec_flags
  );

endinterface

// File: rtl/fpu_selfcheck_seq_pipe.sv
// fpu_selfcheck_pipe: fixed-depth delay line with a per-entry valid bit and
// synchronous flush of all valids.
//   clk, rst (sync, active-low), flush_i : clock / reset / drop all entries
//   valid_i, data_i                      : entry entering stage 0
//   valid_o, data_o                      : entry leaving after DEPTH cycles
//   pend_o                               : some entry is still in flight
//                                          behind the output stage
// DEPTH must be at least 2.
module fpu_selfcheck_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         pend_o
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     data_q [DEPTH];

  // Payload needs no reset: it is only ever looked at under its valid bit.
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], valid_i};
    end
    data_q[0] <= data_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];
  assign pend_o  = |valid_q[DEPTH-2:0];

endmodule

// File: rtl/fpu_selfcheck_seq.sv
// fpu_selfcheck_seq: streams operand pairs from a synchronous vector memory
// into a LAT-cycle add/sub datapath, one pair per cycle, compares each result
// with the expected word and keeps saturating pass/fail counts plus a capture
// of the first mismatch.
//   clk, rst (sync, active-low)
//   start, abort, num_vec, op_sub, round_mode : run control
//   vec (master)                              : vector memory bus
//   dut_s/e/m x/y, dut_sub, dut_round_mode    : registered adder operands
//   dut_sz/ez/mz, dut_flags                   : adder result
//   busy, done, pass_cnt, fail_cnt, fail_seen,
//   first_fail_idx, first_fail_got            : status / results
// Build option FPU_SELFCHECK_FLAGS_EN: when defined, a vector also requires
// dut_flags == vec_flags to pass; otherwise both flag words are ignored.
module fpu_selfcheck_seq
  import fpu_selfcheck_pkg::*;
#(
  parameter int unsigned  EXP_W  = 8,
  parameter int unsigned  MAN_W  = 23,
  parameter int unsigned  ADDR_W = 14,
  parameter int unsigned  LAT    = 2,   // adder latency, legal 1..8
  parameter int unsigned  CNT_W  = 16,
  localparam int unsigned FP_W   = fp_width(EXP_W, MAN_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   num_vec,
  input  logic                op_sub,
  input  logic [1:0]          round_mode,
  fpu_selfcheck_seq_if.master vec,
  output logic                dut_sx,
  output logic [EXP_W-1:0]    dut_ex,
  output logic [MAN_W-1:0]    dut_mx,
  output logic                dut_sy,
  output logic [EXP_W-1:0]    dut_ey,
  output logic [MAN_W-1:0]    dut_my,
  output logic                dut_sub,
  output logic [1:0]          dut_round_mode,
  input  logic                dut_sz,
  input  logic [EXP_W-1:0]    dut_ez,
  input  logic [MAN_W-1:0]    dut_mz,
  input  logic [FLG_W-1:0]    dut_flags,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic                fail_seen,
  output logic [ADDR_W-1:0]   first_fail_idx,
  output logic [FP_W-1:0]     first_fail_got
);

`ifdef FPU_SELFCHECK_FLAGS_EN
  localparam int unsigned PW = ADDR_W + FP_W + FLG_W;
`else
  localparam int unsigned PW = ADDR_W + FP_W;
`endif

  state_e            state_q;
  logic              busy_q, done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q, last_q;
  logic              rd_d1_q;
  logic [ADDR_W-1:0] idx_d1_q;
  logic              sub_q;
  logic [1:0]        rm_q;
  logic [FP_W-1:0]   opx_q, opy_q;
  logic [CNT_W-1:0]  pass_q, fail_q;
  logic              seen_q;
  logic [ADDR_W-1:0] ffidx_q;
  logic [FP_W-1:0]   ffgot_q;

  logic              kill;
  logic [PW-1:0]     pipe_in, pipe_out;
  logic              pipe_valid, pipe_pend;
  logic              cmp_valid, cmp_pass;
  logic [ADDR_W-1:0] cmp_idx;
  logic [FP_W-1:0]   cmp_exp, got;

  assign kill = abort && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign got  = {dut_sz, dut_ez, dut_mz};

`ifdef FPU_SELFCHECK_FLAGS_EN
  assign pipe_in  = {idx_d1_q, vec.vec_exp, vec.vec_flags};
  assign cmp_pass = (got == cmp_exp) && (dut_flags == pipe_out[FLG_W-1:0]);
`else
  logic unused_flags;
  assign unused_flags = ^{dut_flags, vec.vec_flags};
  assign pipe_in  = {idx_d1_q, vec.vec_exp};
  assign cmp_pass = (got == cmp_exp);
`endif

  assign cmp_idx   = pipe_out[PW-1 -: ADDR_W];
  assign cmp_exp   = pipe_out[PW-ADDR_W-1 -: FP_W];
  assign cmp_valid = pipe_valid && !kill;

  // Entries enter one cycle after their address (when memory data arrives),
  // so with the index register in front the scoreboard spans LAT+2 cycles
  // from issue to compare.
  fpu_selfcheck_pipe #(
    .DEPTH (LAT + 1),
    .W     (PW)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (kill),
    .valid_i (rd_d1_q),
    .data_i  (pipe_in),
    .valid_o (pipe_valid),
    .data_o  (pipe_out),
    .pend_o  (pipe_pend)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      last_q   <= '0;
      rd_d1_q  <= 1'b0;
      idx_d1_q <= '0;
      sub_q    <= 1'b0;
      rm_q     <= '0;
      opx_q    <= '0;
      opy_q    <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      seen_q   <= 1'b0;
      ffidx_q  <= '0;
      ffgot_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_d1_q  <= rd_en_q && !kill;
      idx_d1_q <= addr_q;

      if (rd_d1_q) begin
        opx_q <= vec.vec_x;
        opy_q <= vec.vec_y;
      end

      if (cmp_valid) begin
        if (cmp_pass) begin
          pass_q <= (pass_q == '1) ? pass_q : pass_q + 1'b1;
        end else begin
          fail_q <= (fail_q == '1) ? fail_q : fail_q + 1'b1;
          if (!seen_q) begin
            seen_q  <= 1'b1;
            ffidx_q <= cmp_idx;
            ffgot_q <= got;
          end
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pass_q  <= '0;
            fail_q  <= '0;
            seen_q  <= 1'b0;
            ffidx_q <= '0;
            ffgot_q <= '0;
            sub_q   <= op_sub;
            rm_q    <= round_mode;
            last_q  <= num_vec - 1'b1;
            addr_q  <= '0;
            if (num_vec != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
          end else if (addr_q == last_q) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Leave when the entry at the output (if any) is the last one, so
          // its counter update and done land on the same edge.
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!rd_d1_q && !pipe_pend) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec.vec_rd_en    = rd_en_q;
  assign vec.vec_addr     = addr_q;
  assign {dut_sx, dut_ex, dut_mx} = opx_q;
  assign {dut_sy, dut_ey, dut_my} = opy_q;
  assign dut_sub          = sub_q;
  assign dut_round_mode   = rm_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass_cnt         = pass_q;
  assign fail_cnt         = fail_q;
  assign fail_seen        = seen_q;
  assign first_fail_idx   = ffidx_q;
  assign first_fail_got   = ffgot_q;

endmodule
